// File: rtl/crossbar_pkg.sv
// crossbar_pkg: shared constants for the 2x2 crossbar scheduler
package crossbar_pkg;
  localparam int DATA_W = 4;
  localparam logic ROUTE_STRAIGHT = 1'b0;
  localparam logic ROUTE_CROSS = 1'b1;
  localparam logic DEST_OUT1 = 1'b0;
  localparam logic DEST_OUT2 = 1'b1;
endpackage

// File: rtl/crossbar_in_fifo.sv
// crossbar_in_fifo: sync FIFO of {dest, data}; extra pointer bit separates full from empty
module crossbar_in_fifo #(
  parameter int W = 5,
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] din,
  output logic         full,
  output logic         empty,
  output logic [W-1:0] head
);
  localparam int AW = $clog2(DEPTH);
  logic [W-1:0] mem [DEPTH];
  logic [AW:0] wp, rp;
  assign empty = wp == rp;
  assign full = (wp ^ rp) == {1'b1, {AW{1'b0}}};
  assign head = mem[rp[AW-1:0]];
  always_ff @(posedge clk) begin
    if (rst) begin
      wp <= '0;
      rp <= '0;
    end else begin
      if (push && !full) begin
        mem[wp[AW-1:0]] <= din;
        wp <= wp + (AW+1)'(1);
      end
      if (pop && !empty) rp <= rp + (AW+1)'(1);
    end
  end
endmodule

// File: rtl/crossbar_2x2_sched.sv
// crossbar_2x2_sched: buffers two tagged input streams and schedules them onto the 2x2 crossbar.
// CROSSBAR_SCHED_STATS_EN adds a saturating conflict_cnt output.
module crossbar_2x2_sched
  import crossbar_pkg::*;
#(
  parameter int DATA_W = crossbar_pkg::DATA_W,
  parameter int DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in1_valid,
  output logic              in1_ready,
  input  logic [DATA_W-1:0] in1_data,
  input  logic              in1_dest,
  input  logic              in2_valid,
  output logic              in2_ready,
  input  logic [DATA_W-1:0] in2_data,
  input  logic              in2_dest,
  input  logic              out1_ready,
  input  logic              out2_ready,
  output logic [DATA_W-1:0] xbar_in1,
  output logic [DATA_W-1:0] xbar_in2,
  output logic              xbar_control,
  output logic              out1_valid,
  output logic              out2_valid
`ifdef CROSSBAR_SCHED_STATS_EN
  , output logic [7:0]      conflict_cnt
`endif
);
  logic full1, full2, empty1, empty2, pop1, pop2, e1, e2, conflict, prio;
  logic [DATA_W:0] head1, head2;
  assign in1_ready = !full1 && !rst;
  assign in2_ready = !full2 && !rst;
  crossbar_in_fifo #(.W(DATA_W+1), .DEPTH(DEPTH)) u_fifo1 (
    .clk(clk), .rst(rst), .push(in1_valid && in1_ready), .pop(pop1),
    .din({in1_dest, in1_data}), .full(full1), .empty(empty1), .head(head1)
  );
  crossbar_in_fifo #(.W(DATA_W+1), .DEPTH(DEPTH)) u_fifo2 (
    .clk(clk), .rst(rst), .push(in2_valid && in2_ready), .pop(pop2),
    .din({in2_dest, in2_data}), .full(full2), .empty(empty2), .head(head2)
  );
  // on a same-destination conflict prio picks the winner; otherwise every eligible head pops
  always_comb begin
    e1 = !empty1 && (head1[DATA_W] == DEST_OUT2 ? out2_ready : out1_ready);
    e2 = !empty2 && (head2[DATA_W] == DEST_OUT2 ? out2_ready : out1_ready);
    conflict = e1 && e2 && head1[DATA_W] == head2[DATA_W];
    pop1 = e1 && !(conflict && prio);
    pop2 = e2 && !(conflict && !prio);
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      xbar_in1 <= '0;
      xbar_in2 <= '0;
      xbar_control <= ROUTE_STRAIGHT;
      out1_valid <= 1'b0;
      out2_valid <= 1'b0;
      prio <= 1'b0;
    end else begin
      xbar_in1 <= pop1 ? head1[DATA_W-1:0] : '0;
      xbar_in2 <= pop2 ? head2[DATA_W-1:0] : '0;
      xbar_control <= pop1 ? (head1[DATA_W] == DEST_OUT2 ? ROUTE_CROSS : ROUTE_STRAIGHT)
                    : pop2 ? (head2[DATA_W] == DEST_OUT2 ? ROUTE_STRAIGHT : ROUTE_CROSS)
                    : xbar_control;
      out1_valid <= (pop1 && head1[DATA_W] == DEST_OUT1) || (pop2 && head2[DATA_W] == DEST_OUT1);
      out2_valid <= (pop1 && head1[DATA_W] == DEST_OUT2) || (pop2 && head2[DATA_W] == DEST_OUT2);
      prio <= prio ^ conflict;
    end
  end
`ifdef CROSSBAR_SCHED_STATS_EN
  always_ff @(posedge clk) begin
    if (rst) conflict_cnt <= '0;
    else if (conflict && conflict_cnt != 8'hFF) conflict_cnt <= conflict_cnt + 8'd1;
  end
`endif
endmodule
